ddr_step_sequencer: RTL and testbench

Producer side of the arrow/move interface consumed by the lives/arrow display. It runs a 4-deep arrow queue that advances on every metronome beat, decodes the player's buttons into a move code, and judges each beat against the target arrow. It maintains lives, score and game-over, and sits between the button/metronome inputs and the display block.

---
 rtl/ddr_definitions.sv | 82 ++++++++
 rtl/ddr_beat_sync.sv | 32 +++
 rtl/ddr_step_sequencer.sv | 145 ++++++++++++++
 tb/tb_ddr_step_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_definitions.sv
// Shared codes for the DDR step sequencer: game states, arrow codes, LFSR taps.
// Optional DDR_COMBO_EN adds two-button combo decode and combo arrow generation.
package ddr_definitions;

  localparam int STATE_BITS      = 1;
  localparam int NUM_ARROWS_BITS = 4;

  typedef logic [STATE_BITS:0]      game_state_t;
  typedef logic [NUM_ARROWS_BITS:0] arrow_t;

  localparam game_state_t STATE_START = 2'd0;
  localparam game_state_t STATE_GAME  = 2'd1;
  localparam game_state_t STATE_LOSE  = 2'd2;

  localparam arrow_t ARROW_UP         = 5'd10;
  localparam arrow_t ARROW_DOWN       = 5'd11;
  localparam arrow_t ARROW_LEFT       = 5'd12;
  localparam arrow_t ARROW_RIGHT      = 5'd13;
  localparam arrow_t ARROW_UP_DOWN    = 5'd14;
  localparam arrow_t ARROW_UP_LEFT    = 5'd15;
  localparam arrow_t ARROW_UP_RIGHT   = 5'd16;
  localparam arrow_t ARROW_DOWN_LEFT  = 5'd17;
  localparam arrow_t ARROW_DOWN_RIGHT = 5'd18;
  localparam arrow_t ARROW_LEFT_RIGHT = 5'd19;
  localparam arrow_t ARROW_NONE       = 5'd20;
  localparam arrow_t ARROW_INVALID    = 5'd31;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_OVER
  } seq_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Buttons are ordered {up, down, left, right}.
  function automatic arrow_t decode_btn(input logic [3:0] b);
    arrow_t a;
    case (b)
      4'b0000: a = ARROW_NONE;
      4'b1000: a = ARROW_UP;
      4'b0100: a = ARROW_DOWN;
      4'b0010: a = ARROW_LEFT;
      4'b0001: a = ARROW_RIGHT;
`ifdef DDR_COMBO_EN
      4'b1100: a = ARROW_UP_DOWN;
      4'b1010: a = ARROW_UP_LEFT;
      4'b1001: a = ARROW_UP_RIGHT;
      4'b0110: a = ARROW_DOWN_LEFT;
      4'b0101: a = ARROW_DOWN_RIGHT;
      4'b0011: a = ARROW_LEFT_RIGHT;
`endif
      default: a = ARROW_INVALID;
    endcase
    return a;
  endfunction

  function automatic arrow_t gen_arrow(input logic [15:0] l);
    arrow_t a;
    if (l[2:0] == 3'd0) begin
      a = ARROW_NONE;
`ifdef DDR_COMBO_EN
    end else if (l[2:0] == 3'd7) begin
      a = ARROW_UP_DOWN + {2'b00, l[7:5] % 3'd6};
`endif
    end else begin
      case (l[4:3])
        2'd0:    a = ARROW_UP;
        2'd1:    a = ARROW_DOWN;
        2'd2:    a = ARROW_LEFT;
        default: a = ARROW_RIGHT;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/ddr_beat_sync.sv
// Two-flop synchronizer with a registered rising-edge pulse per bit.
module ddr_beat_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q, rise_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/ddr_step_sequencer.sv
// Arrow queue, move capture and beat judge for the DDR game.
// Build with DDR_COMBO_EN for two-button combo moves and combo arrows.
module ddr_step_sequencer
  import ddr_definitions::*;
#(
  parameter logic [2:0]  LIVES_INIT = 3'd5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [13:0] SCORE_MAX  = 14'd9999
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     metronome_clk,
  input  logic [STATE_BITS:0]      state,
  input  logic [3:0]               btn,
  output logic [NUM_ARROWS_BITS:0] cur_arrow0,
  output logic [NUM_ARROWS_BITS:0] cur_arrow1,
  output logic [NUM_ARROWS_BITS:0] cur_arrow2,
  output logic [NUM_ARROWS_BITS:0] cur_arrow3,
  output logic [NUM_ARROWS_BITS:0] player_move,
  output logic [2:0]               lives,
  output logic [13:0]              score,
  output logic                     hit,
  output logic                     miss,
  output logic                     game_over
);

  logic       beat;
  logic       met_level_unused;
  logic [3:0] btn_sync;
  logic [3:0] btn_rise_unused;
  arrow_t     btn_move;

  ddr_beat_sync #(.WIDTH(1)) u_met_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (metronome_clk),
    .level_o (met_level_unused),
    .rise_o  (beat)
  );

  ddr_beat_sync #(.WIDTH(4)) u_btn_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (btn),
    .level_o (btn_sync),
    .rise_o  (btn_rise_unused)
  );

  assign btn_move = decode_btn(btn_sync);

  seq_state_e        seq_q, seq_d;
  arrow_t [3:0]      arrows_q, arrows_d;
  arrow_t            move_q, move_d;
  logic [2:0]        lives_q, lives_d;
  logic [13:0]       score_q, score_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              hit_q, hit_d, miss_q, miss_d;
  arrow_t            target;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    seq_d    = seq_q;
    arrows_d = arrows_q;
    move_d   = move_q;
    lives_d  = lives_q;
    score_d  = score_q;
    lfsr_d   = lfsr_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    target   = arrows_q[3];

    case (seq_q)
      SEQ_IDLE: begin
        if (state == STATE_GAME) begin
          seq_d    = SEQ_RUN;
          lives_d  = LIVES_INIT;
          score_d  = '0;
          arrows_d = {4{ARROW_NONE}};
          move_d   = ARROW_NONE;
        end
      end

      SEQ_RUN: begin
        if (state != STATE_GAME) begin
          seq_d = SEQ_IDLE;
        end else if (beat) begin
          if (target != ARROW_NONE && move_q == target) begin
            hit_d = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + 14'd1;
          end else if (target != ARROW_NONE || move_q != ARROW_NONE) begin
            miss_d = 1'b1;
            if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
            if (lives_q <= 3'd1) seq_d = SEQ_OVER;
          end
          arrows_d = {arrows_q[2:0], gen_arrow(lfsr_q)};
          lfsr_d   = lfsr_step(lfsr_q);
          // Capture restarts on the beat; a press landing here counts next beat.
          move_d   = ARROW_NONE;
        end else if (move_q == ARROW_NONE) begin
          move_d = btn_move;
        end
      end

      SEQ_OVER: begin
        if (state != STATE_GAME) seq_d = SEQ_IDLE;
      end

      default: seq_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q    <= SEQ_IDLE;
      arrows_q <= {4{ARROW_NONE}};
      move_q   <= ARROW_NONE;
      lives_q  <= LIVES_INIT;
      score_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      arrows_q <= arrows_d;
      move_q   <= move_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      lfsr_q   <= lfsr_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign cur_arrow0  = arrows_q[0];
  assign cur_arrow1  = arrows_q[1];
  assign cur_arrow2  = arrows_q[2];
  assign cur_arrow3  = arrows_q[3];
  assign player_move = move_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign game_over   = (seq_q == SEQ_OVER);

endmodule

// File: tb/tb_ddr_step_sequencer.sv
// Directed bench: a beat-by-beat vector table for one full game, then hand sequences.
module tb_ddr_step_sequencer;
  import ddr_definitions::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        metronome_clk;
  logic [1:0]  state;
  logic [3:0]  btn;
  logic [4:0]  cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3, player_move;
  logic [2:0]  lives;
  logic [13:0] score;
  logic        hit, miss, game_over;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr_step_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .metronome_clk (metronome_clk),
    .state         (state),
    .btn           (btn),
    .cur_arrow0    (cur_arrow0),
    .cur_arrow1    (cur_arrow1),
    .cur_arrow2    (cur_arrow2),
    .cur_arrow3    (cur_arrow3),
    .player_move   (player_move),
    .lives         (lives),
    .score         (score),
    .hit           (hit),
    .miss          (miss),
    .game_over     (game_over)
  );

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  // Sixth LFSR arrow (seed state 0x0E27, low bits 3'b111) and two-button decode differ by build.
`ifdef DDR_COMBO_EN
  localparam arrow_t A6      = ARROW_UP_LEFT;
  localparam arrow_t TWO_BTN = ARROW_UP_LEFT;
`else
  localparam arrow_t A6      = ARROW_UP;
  localparam arrow_t TWO_BTN = ARROW_INVALID;
`endif

  localparam arrow_t N = ARROW_NONE;
  localparam arrow_t U = ARROW_UP;
  localparam arrow_t D = ARROW_DOWN;
  localparam arrow_t L = ARROW_LEFT;
  localparam arrow_t R = ARROW_RIGHT;

  typedef struct {
    logic [3:0]  b1;
    logic [3:0]  b2;
    logic [4:0]  mv;
    logic        h;
    logic        m;
    logic [2:0]  lv;
    logic [13:0] sc;
    logic        go;
    logic [4:0]  a0, a1, a2, a3;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_values(input string tag);
    check({tag, " arrow0"}, 32'(cur_arrow0), 32'(N));
    check({tag, " arrow1"}, 32'(cur_arrow1), 32'(N));
    check({tag, " arrow2"}, 32'(cur_arrow2), 32'(N));
    check({tag, " arrow3"}, 32'(cur_arrow3), 32'(N));
    check({tag, " move"},   32'(player_move), 32'(N));
    check({tag, " lives"},  32'(lives), 32'd5);
    check({tag, " score"},  32'(score), 32'd0);
    check({tag, " hit"},    32'(hit), 32'd0);
    check({tag, " miss"},   32'(miss), 32'd0);
    check({tag, " game_over"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    // Arrow stream from seed 0xACE1: UP NONE NONE RIGHT DOWN A6 LEFT DOWN UP UP LEFT NONE DOWN.
    //          b1            b2       mv       h  m  lv sc go  a0 a1  a2  a3
    vecs[0]  = '{B_NONE,       B_NONE,  N,       0, 0, 5, 0, 0, U, N,  N,  N};
    vecs[1]  = '{B_NONE,       B_NONE,  N,       0, 0, 5, 0, 0, N, U,  N,  N};
    vecs[2]  = '{B_NONE,       B_NONE,  N,       0, 0, 5, 0, 0, N, N,  U,  N};
    vecs[3]  = '{B_NONE,       B_NONE,  N,       0, 0, 5, 0, 0, R, N,  N,  U};
    vecs[4]  = '{B_UP,         B_UP,    U,       1, 0, 5, 1, 0, D, R,  N,  N};
    vecs[5]  = '{B_NONE,       B_NONE,  N,       0, 0, 5, 1, 0, A6, D, R,  N};
    vecs[6]  = '{B_DOWN,       B_DOWN,  D,       0, 1, 4, 1, 0, L, A6, D,  R};
    vecs[7]  = '{B_LEFT,       B_RIGHT, L,       0, 1, 3, 1, 0, D, L,  A6, D};
    vecs[8]  = '{B_UP|B_LEFT,  B_UP|B_LEFT, TWO_BTN, 0, 1, 2, 1, 0, U, D, L, A6};
    vecs[9]  = '{B_NONE,       B_NONE,  N,       0, 1, 1, 1, 0, U, U,  D,  L};
    vecs[10] = '{B_DOWN,       B_DOWN,  D,       0, 1, 0, 1, 1, L, U,  U,  D};
    vecs[11] = '{B_NONE,       B_NONE,  N,       0, 0, 0, 1, 1, L, U,  U,  D};

    rst = 1'b1;
    metronome_clk = 1'b0;
    state = STATE_START;
    btn = B_NONE;
    step(3);
    rst = 1'b0;
    step(1);
    check_idle_values("reset");

    state = STATE_GAME;
    step(2);

    for (int i = 0; i < 12; i++) begin
      btn = vecs[i].b1;
      step(4);
      if (vecs[i].b2 != vecs[i].b1) begin
        btn = vecs[i].b2;
        step(4);
      end
      check($sformatf("row%0d move", i), 32'(player_move), 32'(vecs[i].mv));
      btn = B_NONE;
      step(3);
      metronome_clk = 1'b1;
      step(4);
      check($sformatf("row%0d hit", i),   32'(hit),   32'(vecs[i].h));
      check($sformatf("row%0d miss", i),  32'(miss),  32'(vecs[i].m));
      check($sformatf("row%0d lives", i), 32'(lives), 32'(vecs[i].lv));
      check($sformatf("row%0d score", i), 32'(score), 32'(vecs[i].sc));
      check($sformatf("row%0d game_over", i), 32'(game_over), 32'(vecs[i].go));
      check($sformatf("row%0d arrow0", i), 32'(cur_arrow0), 32'(vecs[i].a0));
      check($sformatf("row%0d arrow1", i), 32'(cur_arrow1), 32'(vecs[i].a1));
      check($sformatf("row%0d arrow2", i), 32'(cur_arrow2), 32'(vecs[i].a2));
      check($sformatf("row%0d arrow3", i), 32'(cur_arrow3), 32'(vecs[i].a3));
      metronome_clk = 1'b0;
      step(1);
      check($sformatf("row%0d pulse width", i), 32'({hit, miss}), 32'd0);
      step(3);
    end

    // Leaving the game clears OVER; lives/score hold until the next start.
    state = STATE_START;
    step(3);
    check("idle game_over", 32'(game_over), 32'd0);
    check("idle lives hold", 32'(lives), 32'd0);
    check("idle score hold", 32'(score), 32'd1);
    state = STATE_GAME;
    step(2);
    check_idle_values("restart");

    // Synced press arrives in the beat cycle: cleared on this beat, latched for the next.
    metronome_clk = 1'b1;
    step(1);
    btn = B_UP;
    step(3);
    check("same-cycle hit", 32'(hit), 32'd0);
    check("same-cycle miss", 32'(miss), 32'd0);
    check("same-cycle move cleared", 32'(player_move), 32'(N));
    check("restart lfsr arrow12", 32'(cur_arrow0), 32'(N));
    step(1);
    check("same-cycle move relatched", 32'(player_move), 32'(U));
    metronome_clk = 1'b0;
    btn = B_NONE;
    step(4);
    metronome_clk = 1'b1;
    step(4);
    check("next-beat miss", 32'(miss), 32'd1);
    check("next-beat lives", 32'(lives), 32'd4);
    check("restart lfsr arrow13", 32'(cur_arrow0), 32'(D));
    metronome_clk = 1'b0;
    step(2);

    // Asynchronous reset mid-game.
    #2 rst = 1'b1;
    step(1);
    check_idle_values("mid-run reset");
    rst = 1'b0;
    state = STATE_START;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
